// File: rtl/acr_packet_generator.sv
// ============================================================================
// Module      : acr_packet_generator
// Description : Measures CTS over N/128 audio-sample windows and emits
//               HDMI Audio Clock Regeneration packets with lock tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acr_packet_generator #(
    parameter int CTS_WIDTH      = 20,
    parameter int CTS_TIMEOUT    = (1 << CTS_WIDTH) - 1,
    parameter int LOCK_TOLERANCE = 2,
    parameter int LOCK_COUNT     = 4,
    parameter int SEND_UNLOCKED  = 1
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic [2:0]       audio_rate_sel,
    input  logic             sample_tick,
    input  logic             packet_ready,
    output logic             packet_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub,
    output logic [19:0]      cts,
    output logic             cts_locked,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [2:0]             rate_q;
    logic                   rate_chg;
    logic [7:0]             tick_cnt;
    logic [CTS_WIDTH-1:0]   cyc_cnt, cts_q, delta;
    logic [MW-1:0]          match_cnt, match_nx;
    logic                   prev_valid, pending;
    logic [19:0]            n_val;
    logic [7:0]             w_len;
    logic                   rate_hold, boundary, capture, expire, stable, locked_nx;

    always_comb begin
        n_val = 20'd0;
        w_len = 8'd0;
        case (rate_q)
            3'd0: begin n_val = 20'd4096;  w_len = 8'd32;  end
            3'd1: begin n_val = 20'd6272;  w_len = 8'd49;  end
            3'd2: begin n_val = 20'd6144;  w_len = 8'd48;  end
            3'd3: begin n_val = 20'd12544; w_len = 8'd98;  end
            3'd4: begin n_val = 20'd12288; w_len = 8'd96;  end
            3'd5: begin n_val = 20'd25088; w_len = 8'd196; end
            3'd6: begin n_val = 20'd24576; w_len = 8'd192; end
            default: begin n_val = 20'd0;  w_len = 8'd0;   end
        endcase
    end

    always_comb begin
        // Events are frozen while a new rate is being taken up
        rate_hold = (audio_rate_sel != rate_q) || rate_chg;
        boundary  = sample_tick && (state != S_IDLE) && !rate_hold
                    && (tick_cnt == w_len - 8'd1);
        capture   = boundary && (state == S_MEASURE);
        expire    = (state == S_MEASURE) && !boundary && !rate_hold
                    && (cyc_cnt == CTS_WIDTH'(CTS_TIMEOUT));
        delta     = (cyc_cnt >= cts_q) ? (cyc_cnt - cts_q) : (cts_q - cyc_cnt);
        stable    = prev_valid && (delta <= CTS_WIDTH'(LOCK_TOLERANCE));
        match_nx  = MW'(0);
        if (stable)
            match_nx = (match_cnt == MW'(LOCK_COUNT)) ? match_cnt : match_cnt + MW'(1);
        locked_nx = stable && (match_nx == MW'(LOCK_COUNT));

        state_nx = state;
        if (rate_chg)
            state_nx = (rate_q == 3'd7) ? S_IDLE : S_ARM;
        else if (boundary && state == S_ARM)
            state_nx = S_MEASURE;
        else if (expire)
            state_nx = S_ARM;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset)
            state <= S_ARM;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            rate_q     <= 3'd2;
            rate_chg   <= 1'b0;
            tick_cnt   <= 8'd0;
            cyc_cnt    <= '0;
            cts_q      <= '0;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
            cts_locked <= 1'b0;
            timeout    <= 1'b0;
            pending    <= 1'b0;
        end else begin
            rate_chg <= (audio_rate_sel != rate_q);
            if (audio_rate_sel != rate_q)
                rate_q <= audio_rate_sel;

            if (rate_chg) begin
                tick_cnt   <= 8'd0;
                cyc_cnt    <= '0;
                match_cnt  <= '0;
                prev_valid <= 1'b0;
                cts_locked <= 1'b0;
                pending    <= 1'b0;
            end else begin
                if (!rate_hold) begin
                    if (state == S_IDLE) begin
                        tick_cnt <= 8'd0;
                        cyc_cnt  <= '0;
                    end else begin
                        if (sample_tick)
                            tick_cnt <= boundary ? 8'd0 : tick_cnt + 8'd1;
                        if (boundary)
                            cyc_cnt <= CTS_WIDTH'(1);
                        else if (expire)
                            cyc_cnt <= '0;
                        else if (state == S_MEASURE)
                            cyc_cnt <= cyc_cnt + CTS_WIDTH'(1);
                    end
                end

                if (capture) begin
                    cts_q      <= cyc_cnt;
                    prev_valid <= 1'b1;
                    match_cnt  <= match_nx;
                    cts_locked <= locked_nx;
                    timeout    <= 1'b0;
                end else if (expire) begin
                    timeout    <= 1'b1;
                    cts_locked <= 1'b0;
                    match_cnt  <= '0;
                    prev_valid <= 1'b0;
                end

                // A capture in the accept cycle re-arms the packet with the new CTS
                if (capture && ((SEND_UNLOCKED != 0) || locked_nx))
                    pending <= 1'b1;
                else if (pending && packet_ready)
                    pending <= 1'b0;
            end
        end
    end

    assign packet_valid = pending;
    assign cts          = 20'(cts_q);
    assign header       = {8'd0, 8'd0, 8'd1};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sub
            assign sub[i] = {n_val[7:0], n_val[15:8], {4'd0, n_val[19:16]},
                             cts[7:0], cts[15:8], {4'd0, cts[19:16]}, 8'd0};
        end
    endgenerate

endmodule

`default_nettype wire
